// File: rtl/core101_fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// fault cause codes, the reset instruction and a counter sizing helper.
package core101_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [1:0] CAUSE_NONE       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'b10;

  // addi x0, x0, 0
  localparam logic [31:0] INS_NOP = 32'h0000_0013;

  // Bits needed to hold 0..t, never less than one.
  function automatic int unsigned cnt_width(input int unsigned t);
    if (t == 0) return 1;
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Loadable saturating down-counter used to bound the memory ack wait.
module fetch_timeout_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o,
  output logic             last_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load has priority; decrement stops at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction-fetch sequencer: latches the PC, runs a req/ack handshake with
// instruction memory, then strobes IR/PC set for one cycle. Flags misaligned
// PCs and ack timeouts as a sticky fault cleared only by flush.
module ins_fetch_unit
  import core101_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned INS_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  ins_fetch_unit_clock_in,
  input  logic                  ins_fetch_unit_reset_in,
  input  logic [ADDR_WIDTH-1:0] ins_fetch_unit_pc_addr_in,
  input  logic                  ins_fetch_unit_start_in,
  input  logic                  ins_fetch_unit_flush_in,
  output logic                  ins_fetch_unit_mem_req_out,
  output logic [ADDR_WIDTH-1:0] ins_fetch_unit_mem_addr_out,
  input  logic                  ins_fetch_unit_mem_ack_in,
  input  logic [INS_WIDTH-1:0]  ins_fetch_unit_mem_data_in,
  output logic [INS_WIDTH-1:0]  ins_fetch_unit_ins_out,
  output logic                  ins_fetch_unit_ir_set_out,
  output logic                  ins_fetch_unit_pc_set_out,
  output logic                  ins_fetch_unit_busy_out,
  output logic                  ins_fetch_unit_fault_out,
  output logic [1:0]            ins_fetch_unit_fault_cause_out
);

  localparam int unsigned        CNT_W      = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(TIMEOUT_CYCLES);
  localparam bit                 TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  fetch_state_e          state_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [INS_WIDTH-1:0]  ins_q;
  logic                  ir_set_q;
  logic                  pc_set_q;
  logic                  fault_q;
  logic [1:0]            cause_q;

  logic aligned;
  logic cnt_load;
  logic cnt_en;
  logic cnt_zero;
  logic cnt_last;
  logic timeout_hit;

  assign aligned = (ins_fetch_unit_pc_addr_in[1:0] == 2'b00);

  // Counter is armed on an accepted start and ticks on every ack-less REQ cycle.
  assign cnt_load = (state_q == ST_IDLE) && ins_fetch_unit_start_in && aligned &&
                    !ins_fetch_unit_flush_in;
  assign cnt_en   = (state_q == ST_REQ) && !ins_fetch_unit_mem_ack_in &&
                    !ins_fetch_unit_flush_in;

  // Expire on the last counted REQ cycle; an ack in that same cycle wins.
  assign timeout_hit = TIMEOUT_EN && (cnt_last || cnt_zero);

  fetch_timeout_cnt #(
    .WIDTH (CNT_W)
  ) u_timeout_cnt (
    .clk_i      (ins_fetch_unit_clock_in),
    .rst_i      (ins_fetch_unit_reset_in),
    .load_i     (cnt_load),
    .load_val_i (CNT_LOAD),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero),
    .last_o     (cnt_last)
  );

  // Fetch FSM with registered handshake, strobe and fault outputs.
  always_ff @(posedge ins_fetch_unit_clock_in or posedge ins_fetch_unit_reset_in) begin
    if (ins_fetch_unit_reset_in) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ins_q      <= INS_WIDTH'(INS_NOP);
      ir_set_q   <= 1'b0;
      pc_set_q   <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= CAUSE_NONE;
    end else begin
      ir_set_q <= 1'b0;
      pc_set_q <= 1'b0;
      if (ins_fetch_unit_flush_in) begin
        state_q   <= ST_IDLE;
        mem_req_q <= 1'b0;
        fault_q   <= 1'b0;
        cause_q   <= CAUSE_NONE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ins_fetch_unit_start_in) begin
              if (!aligned) begin
                state_q <= ST_FAULT;
                fault_q <= 1'b1;
                cause_q <= CAUSE_MISALIGNED;
              end else begin
                state_q    <= ST_REQ;
                mem_req_q  <= 1'b1;
                mem_addr_q <= ins_fetch_unit_pc_addr_in;
              end
            end
          end
          ST_REQ: begin
            if (ins_fetch_unit_mem_ack_in) begin
              state_q   <= ST_ISSUE;
              mem_req_q <= 1'b0;
              ins_q     <= ins_fetch_unit_mem_data_in;
              ir_set_q  <= 1'b1;
              pc_set_q  <= 1'b1;
            end else if (timeout_hit) begin
              state_q   <= ST_FAULT;
              mem_req_q <= 1'b0;
              fault_q   <= 1'b1;
              cause_q   <= CAUSE_TIMEOUT;
            end
          end
          ST_ISSUE: begin
            state_q <= ST_IDLE;
          end
          ST_FAULT: begin
            state_q <= ST_FAULT;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ins_fetch_unit_mem_req_out     = mem_req_q;
  assign ins_fetch_unit_mem_addr_out    = mem_addr_q;
  assign ins_fetch_unit_ins_out         = ins_q;
  assign ins_fetch_unit_ir_set_out      = ir_set_q;
  assign ins_fetch_unit_pc_set_out      = pc_set_q;
  assign ins_fetch_unit_busy_out        = (state_q != ST_IDLE);
  assign ins_fetch_unit_fault_out       = fault_q;
  assign ins_fetch_unit_fault_cause_out = cause_q;

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Directed bench for ins_fetch_unit: default-timeout instance plus a
// TIMEOUT_CYCLES=3 instance sharing the same stimulus.
module tb_ins_fetch_unit;

  logic        clk;
  logic        rst;
  logic [63:0] pc;
  logic        start;
  logic        flush;
  logic        ack;
  logic [31:0] data;

  logic        req_a, irs_a, pcs_a, busy_a, fault_a;
  logic [63:0] addr_a;
  logic [31:0] ins_a;
  logic [1:0]  cause_a;

  logic        req_b, irs_b, pcs_b, busy_b, fault_b;
  logic [63:0] addr_b;
  logic [31:0] ins_b;
  logic [1:0]  cause_b;

  int n_tests;
  int n_fail;

  ins_fetch_unit dut (
    .ins_fetch_unit_clock_in        (clk),
    .ins_fetch_unit_reset_in        (rst),
    .ins_fetch_unit_pc_addr_in      (pc),
    .ins_fetch_unit_start_in        (start),
    .ins_fetch_unit_flush_in        (flush),
    .ins_fetch_unit_mem_req_out     (req_a),
    .ins_fetch_unit_mem_addr_out    (addr_a),
    .ins_fetch_unit_mem_ack_in      (ack),
    .ins_fetch_unit_mem_data_in     (data),
    .ins_fetch_unit_ins_out         (ins_a),
    .ins_fetch_unit_ir_set_out      (irs_a),
    .ins_fetch_unit_pc_set_out      (pcs_a),
    .ins_fetch_unit_busy_out        (busy_a),
    .ins_fetch_unit_fault_out       (fault_a),
    .ins_fetch_unit_fault_cause_out (cause_a)
  );

  ins_fetch_unit #(.TIMEOUT_CYCLES(3)) dut3 (
    .ins_fetch_unit_clock_in        (clk),
    .ins_fetch_unit_reset_in        (rst),
    .ins_fetch_unit_pc_addr_in      (pc),
    .ins_fetch_unit_start_in        (start),
    .ins_fetch_unit_flush_in        (flush),
    .ins_fetch_unit_mem_req_out     (req_b),
    .ins_fetch_unit_mem_addr_out    (addr_b),
    .ins_fetch_unit_mem_ack_in      (ack),
    .ins_fetch_unit_mem_data_in     (data),
    .ins_fetch_unit_ins_out         (ins_b),
    .ins_fetch_unit_ir_set_out      (irs_b),
    .ins_fetch_unit_pc_set_out      (pcs_b),
    .ins_fetch_unit_busy_out        (busy_b),
    .ins_fetch_unit_fault_out       (fault_b),
    .ins_fetch_unit_fault_cause_out (cause_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; pc = '0; start = 1'b0; flush = 1'b0; ack = 1'b0; data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_req",   64'(req_a),   64'd0);
    chk("rst_addr",  addr_a,       64'd0);
    chk("rst_ins",   64'(ins_a),   64'h13);
    chk("rst_irs",   64'(irs_a),   64'd0);
    chk("rst_pcs",   64'(pcs_a),   64'd0);
    chk("rst_busy",  64'(busy_a),  64'd0);
    chk("rst_fault", 64'(fault_a), 64'd0);
    chk("rst_cause", 64'(cause_a), 64'd0);

    // Zero-wait fetch at 0x1000
    start = 1'b1; pc = 64'h1000;
    tick();                                 // cycle 1
    start = 1'b0;
    chk("t1_req_c1",  64'(req_a),  64'd1);
    chk("t1_addr_c1", addr_a,      64'h1000);
    chk("t1_busy_c1", 64'(busy_a), 64'd1);
    chk("t1_irs_c1",  64'(irs_a),  64'd0);
    ack = 1'b1; data = 32'h0050_0093;
    tick();                                 // cycle 2
    ack = 1'b0; data = '0;
    chk("t1_ins_c2",  64'(ins_a),  64'h0050_0093);
    chk("t1_irs_c2",  64'(irs_a),  64'd1);
    chk("t1_pcs_c2",  64'(pcs_a),  64'd1);
    chk("t1_req_c2",  64'(req_a),  64'd0);
    chk("t1_busy_c2", 64'(busy_a), 64'd1);
    tick();                                 // cycle 3
    chk("t1_busy_c3", 64'(busy_a), 64'd0);
    chk("t1_irs_c3",  64'(irs_a),  64'd0);
    chk("t1_pcs_c3",  64'(pcs_a),  64'd0);

    // Five wait cycles at 0x2000
    start = 1'b1; pc = 64'h2000;
    tick();
    start = 1'b0; pc = 64'h7777_0000;
    for (int i = 0; i < 5; i++) begin
      chk("t2_req_wait",  64'(req_a), 64'd1);
      chk("t2_addr_wait", addr_a,     64'h2000);
      chk("t2_irs_wait",  64'(irs_a), 64'd0);
      tick();
    end
    chk("t2_req_ack", 64'(req_a), 64'd1);
    ack = 1'b1; data = 32'h1234_5678;
    tick();
    ack = 1'b0; data = '0;
    chk("t2_ins",   64'(ins_a),   64'h1234_5678);
    chk("t2_irs",   64'(irs_a),   64'd1);
    chk("t2_pcs",   64'(pcs_a),   64'd1);
    chk("t2_req",   64'(req_a),   64'd0);
    chk("t2_fault", 64'(fault_a), 64'd0);
    tick();
    chk("t2_busy_end", 64'(busy_a), 64'd0);
    chk("t2_irs_end",  64'(irs_a),  64'd0);

    // Misaligned PC, start ignored in FAULT, flush clears
    start = 1'b1; pc = 64'h1002;
    tick();
    pc = 64'h1000;
    chk("t3_fault", 64'(fault_a), 64'd1);
    chk("t3_cause", 64'(cause_a), 64'd1);
    chk("t3_req",   64'(req_a),   64'd0);
    chk("t3_busy",  64'(busy_a),  64'd1);
    tick();
    chk("t3_fault_hold", 64'(fault_a), 64'd1);
    chk("t3_req_hold",   64'(req_a),   64'd0);
    tick();
    chk("t3_cause_hold", 64'(cause_a), 64'd1);
    chk("t3_req_hold2",  64'(req_a),   64'd0);
    start = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_fault_clr", 64'(fault_a), 64'd0);
    chk("t3_cause_clr", 64'(cause_a), 64'd0);
    chk("t3_busy_clr",  64'(busy_a),  64'd0);
    chk("t3_ins_keep",  64'(ins_a),   64'h1234_5678);

    // Flush coincident with ack discards the data
    start = 1'b1; pc = 64'h3000;
    tick();
    start = 1'b0;
    chk("t5_req", 64'(req_a), 64'd1);
    ack = 1'b1; data = 32'hDEAD_BEEF; flush = 1'b1;
    tick();
    ack = 1'b0; data = '0; flush = 1'b0;
    chk("t5_ins",  64'(ins_a),  64'h1234_5678);
    chk("t5_irs",  64'(irs_a),  64'd0);
    chk("t5_pcs",  64'(pcs_a),  64'd0);
    chk("t5_busy", 64'(busy_a), 64'd0);
    chk("t5_req0", 64'(req_a),  64'd0);
    tick();
    chk("t5_irs_next", 64'(irs_a), 64'd0);

    // Async reset mid-REQ, between edges
    start = 1'b1; pc = 64'h4000;
    tick();
    start = 1'b0;
    chk("t6_req_pre", 64'(req_a), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_req",   64'(req_a),  64'd0);
    chk("t6_addr",  addr_a,      64'd0);
    chk("t6_ins",   64'(ins_a),  64'h13);
    chk("t6_busy",  64'(busy_a), 64'd0);
    chk("t6_ins_b", 64'(ins_b),  64'h13);
    tick();
    rst = 1'b0;
    tick();

    // TIMEOUT_CYCLES=3, no ack: three request cycles then FAULT/10
    start = 1'b1; pc = 64'h5000;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_req_b",   64'(req_b),   64'd1);
      chk("t4_fault_b", 64'(fault_b), 64'd0);
      tick();
    end
    chk("t4_to_fault", 64'(fault_b), 64'd1);
    chk("t4_to_cause", 64'(cause_b), 64'd2);
    chk("t4_to_req",   64'(req_b),   64'd0);
    chk("t4_a_req",    64'(req_a),   64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_clr_fault", 64'(fault_b), 64'd0);
    chk("t4_clr_cause", 64'(cause_b), 64'd0);
    chk("t4_a_busy",    64'(busy_a),  64'd0);

    // Ack on the expiring request cycle wins
    start = 1'b1; pc = 64'h6000;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t4b_req_last", 64'(req_b), 64'd1);
    ack = 1'b1; data = 32'hCAFE_F00D;
    tick();
    ack = 1'b0; data = '0;
    chk("t4b_ins",   64'(ins_b),   64'hCAFE_F00D);
    chk("t4b_irs",   64'(irs_b),   64'd1);
    chk("t4b_pcs",   64'(pcs_b),   64'd1);
    chk("t4b_fault", 64'(fault_b), 64'd0);
    chk("t4b_cause", 64'(cause_b), 64'd0);
    tick();
    chk("t4b_busy",   64'(busy_b),  64'd0);
    chk("t4b_fault2", 64'(fault_b), 64'd0);

    // Ack outside REQ is ignored
    ack = 1'b1; data = 32'h0BAD_0BAD;
    tick();
    ack = 1'b0;
    chk("t7_ins", 64'(ins_a), 64'hCAFE_F00D);
    chk("t7_irs", 64'(irs_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ins_fetch_unit.md
Name: ins_fetch_unit

Overview:
- Instruction-fetch sequencer directly upstream of the datapath's instruction register and PC.
- Takes the PC value from the datapath and runs a req/ack transaction with instruction memory.
- On completion, presents the 32-bit instruction and pulses the IR-set and PC-set strobes consumed by the datapath.
- Detects misaligned PCs and memory timeouts; supports flush on branch redirect.

Parameters:
- ADDR_WIDTH, 64, width of PC/memory address.
- INS_WIDTH, 32, instruction word width.
- TIMEOUT_CYCLES, 255, maximum wait cycles for mem ack after request; 0 disables timeout.

Ports:
- ins_fetch_unit_clock_in  input  1  core clock, rising edge.
- ins_fetch_unit_reset_in  input  1  asynchronous, active-high reset.
- ins_fetch_unit_pc_addr_in  input  ADDR_WIDTH  current PC from datapath.
- ins_fetch_unit_start_in  input  1  control-unit request to fetch at current PC.
- ins_fetch_unit_flush_in  input  1  abort in-flight fetch and clear fault.
- ins_fetch_unit_mem_req_out  output  1  memory request, level, held until ack.
- ins_fetch_unit_mem_addr_out  output  ADDR_WIDTH  latched fetch address.
- ins_fetch_unit_mem_ack_in  input  1  memory ack; data valid in the same cycle.
- ins_fetch_unit_mem_data_in  input  INS_WIDTH  instruction word from memory.
- ins_fetch_unit_ins_out  output  INS_WIDTH  last captured instruction.
- ins_fetch_unit_ir_set_out  output  1  one-cycle strobe to datapath IR set.
- ins_fetch_unit_pc_set_out  output  1  one-cycle strobe to datapath PC set.
- ins_fetch_unit_busy_out  output  1  high in any state other than IDLE.
- ins_fetch_unit_fault_out  output  1  sticky fault flag.
- ins_fetch_unit_fault_cause_out  output  2  00 none, 01 misaligned, 10 timeout.

Behaviour:
- Reset (async, any time, including mid-fetch):
  - state IDLE; mem_req 0, mem_addr 0.
  - ins_out 32'h0000_0013 (NOP); ir_set and pc_set 0; busy 0; fault 0; cause 00; timeout counter 0.
- States: IDLE, REQ, ISSUE, FAULT.
- IDLE:
  - start_in sampled only in IDLE.
  - start=1 with pc_addr[1:0]!=0: go to FAULT, cause 01, no memory request.
  - start=1 and aligned: latch pc_addr into mem_addr, load counter with TIMEOUT_CYCLES, go to REQ.
- REQ:
  - mem_req=1; mem_addr stable.
  - mem_ack=1: capture mem_data into ins_out, go to ISSUE.
  - Otherwise the counter decrements. Counter==0 with no ack (and TIMEOUT_CYCLES!=0): go to FAULT, cause 10.
  - Ack in the same cycle the counter hits 0: ack wins.
- ISSUE:
  - ir_set=1 and pc_set=1 for exactly this one cycle; mem_req=0.
  - Next state IDLE unconditionally.
- FAULT:
  - fault=1 and cause held; mem_req=0.
  - start ignored; exits only on flush.
- Flush (priority below reset, above everything else):
  - In any state, next state IDLE; mem_req deasserts next cycle.
  - An ack coincident with flush is discarded: ins_out unchanged, no strobes.
  - fault and cause cleared. ins_out retains its value.
- mem_ack while not in REQ is ignored.
- Latency:
  - start at cycle 0 gives mem_req from cycle 1.
  - Ack at cycle k (k>=1) gives ir_set/pc_set at cycle k+1.
  - Zero-wait memory: 3 cycles start-to-start, strobe in cycle 2.
- Counter width: clog2(TIMEOUT_CYCLES+1), minimum 1; no wrap (saturates at 0).
- All outputs registered except busy, which is decoded from state.

Decomposition:
- Shared package core101_fetch_pkg:
  - state encoding constants (IDLE=2'd0, REQ=2'd1, ISSUE=2'd2, FAULT=2'd3).
  - fault cause constants (NONE, MISALIGNED, TIMEOUT).
  - NOP constant 32'h0000_0013.
- One natural sub-module: fetch_timeout_cnt, a loadable saturating down-counter with load, enable and zero-flag outputs.

Test Plan:
- Reset, then start with pc=0x1000 and ack in cycle 1 with data 0x00500093 -> mem_req in cycle 1 only, mem_addr=0x1000; ins_out=0x00500093 with ir_set=pc_set=1 in cycle 2 only; busy low in cycle 3.
- Start with pc=0x2000, ack after 5 wait cycles -> mem_req held 5 cycles with stable addr; strobes one cycle after ack; no fault.
- Start with pc=0x1002 -> fault=1, cause=01 next cycle, mem_req never asserted; start ignored until flush; flush clears fault to 0/00.
- TIMEOUT_CYCLES=3, never ack -> FAULT with cause=10 after 3 request cycles; also ack on the expiring cycle -> normal ISSUE, no fault.
- Flush asserted in REQ together with ack (data 0xDEADBEEF) -> ins_out keeps previous value, no strobes, IDLE next cycle, mem_req 0.
- Async reset asserted mid-REQ, between clock edges -> all outputs reset immediately, ins_out=0x00000013.
